// File: rtl/compute_tile_pkg.sv
// Shared types and constants for the compute tile sequencer: opcode encodings,
// sequencer states and the per-opcode tile latency helper.
package compute_tile_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2,
        HALTED = 2'd3
    } seq_state_e;

    // The multiply op is the only multi-cycle operation in the tile.
    function automatic logic [CNT_W-1:0] op_latency(
        input logic [3:0] op,
        input int         lat_default,
        input int         lat_op3
    );
        logic [CNT_W-1:0] lat;
        if (op == OP_MUL) begin
            lat = CNT_W'(lat_op3);
        end else begin
            lat = CNT_W'(lat_default);
        end
        return lat;
    endfunction

endpackage

// File: rtl/compute_tile_sequencer_fifo.sv
// Synchronous instruction FIFO with registered full/empty flags and an
// asynchronous clear; no write-to-read bypass.
module seq_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full_r;
    assign pop_ok_s  = pop && !empty_r;

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage, pointers and flags; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r <= (count_nxt_s == CNT_W'(0));
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/compute_tile_sequencer.sv
// Initiator for one computationTile: queues instructions, issues them one at a
// time, waits the opcode latency and hands the captured result back.
module compute_tile_sequencer #(
    parameter int DATA_W      = 16,
    parameter int OP_W        = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int LAT_DEFAULT = 1,
    parameter int LAT_OP3     = 5
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0] in_op0,
    input  logic [DATA_W-1:0] in_op1,
    output logic [OP_W-1:0]   tile_opcode,
    output logic [DATA_W-1:0] tile_data0,
    output logic [DATA_W-1:0] tile_data1,
    input  logic [DATA_W-1:0] tile_data_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [OP_W-1:0]   res_opcode,
    output logic              busy,
    output logic              halted,
    input  logic              resume
);

    import compute_tile_pkg::*;

    localparam int FW = OP_W + 2 * DATA_W;

    seq_state_e        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [OP_W-1:0]   tile_opcode_r;
    logic [DATA_W-1:0] tile_data0_r;
    logic [DATA_W-1:0] tile_data1_r;
    logic              res_valid_r;
    logic [DATA_W-1:0] res_data_r;
    logic [OP_W-1:0]   res_opcode_r;

    logic [FW-1:0]     fifo_dout_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_pop_s;
    logic [OP_W-1:0]   fifo_op_s;
    logic [DATA_W-1:0] fifo_d0_s;
    logic [DATA_W-1:0] fifo_d1_s;

    // Pops only from IDLE, so a pop can never overlap a pending result.
    assign fifo_pop_s = (state_r == IDLE) && !fifo_empty_s;

    seq_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (in_valid),
        .pop   (fifo_pop_s),
        .din   ({in_opcode, in_op0, in_op1}),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign fifo_op_s = fifo_dout_s[FW-1 -: OP_W];
    assign fifo_d0_s = fifo_dout_s[2*DATA_W-1 -: DATA_W];
    assign fifo_d1_s = fifo_dout_s[DATA_W-1:0];

    // Sequencer FSM with latency counter, tile drive and result capture.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            tile_opcode_r <= '0;
            tile_data0_r  <= '0;
            tile_data1_r  <= '0;
            res_valid_r   <= 1'b0;
            res_data_r    <= '0;
            res_opcode_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        if (fifo_op_s == OP_W'(OP_NOP)) begin
                            state_r <= IDLE;
                        end else if (fifo_op_s == OP_W'(OP_HALT)) begin
                            state_r <= HALTED;
                        end else begin
                            tile_opcode_r <= fifo_op_s;
                            tile_data0_r  <= fifo_d0_s;
                            tile_data1_r  <= fifo_d1_s;
                            cnt_r         <= op_latency(4'(fifo_op_s), LAT_DEFAULT, LAT_OP3);
                            state_r       <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Capture on the last latency cycle so the opcode is live exactly LAT cycles.
                    if (cnt_r == CNT_W'(1)) begin
                        res_data_r    <= tile_data_out;
                        res_opcode_r  <= tile_opcode_r;
                        res_valid_r   <= 1'b1;
                        tile_opcode_r <= '0;
                        cnt_r         <= '0;
                        state_r       <= RESULT;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    tile_opcode_r <= '0;
                    res_valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = !fifo_full_s;
    assign tile_opcode = tile_opcode_r;
    assign tile_data0  = tile_data0_r;
    assign tile_data1  = tile_data1_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_opcode  = res_opcode_r;
    assign busy        = (state_r != IDLE) || !fifo_empty_s;
    assign halted      = (state_r == HALTED);

endmodule
